// File: rtl/pe_dbuf.sv
// Processing element: forwarding operand registers, pipelined W x W multiplier,
// block accumulator with optional saturation, and a double-buffered drain register.
module pe_dbuf #(
  parameter int W          = 8,
  parameter int ACCW       = 32,
  parameter int MUL_STAGES = 2,
  parameter int SAT        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            a_valid,
  input  logic            b_valid,
  input  logic            signed_mode,
  output logic [W-1:0]    a_out,
  output logic [W-1:0]    b_out,
  output logic            a_valid_out,
  output logic            b_valid_out,
  input  logic            acc_clear_block,
  input  logic            acc_commit,
  input  logic            drain_shift,
  input  logic [ACCW-1:0] drain_in,
  input  logic            drain_in_valid,
  output logic [ACCW-1:0] drain_out,
  output logic            drain_out_valid,
  output logic            sat_flag
);

  localparam int PW = 2 * W;

  if (ACCW < 2 * W) begin : g_bad_accw
    $error("pe_dbuf: ACCW must be at least 2*W");
  end
  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("pe_dbuf: MUL_STAGES must be in 1..4");
  end

  logic [W-1:0]    a_q, b_q;
  logic            a_vld_q, b_vld_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            sat_q, sat_d;
  logic [ACCW-1:0] shadow_q, shadow_d;
  logic            shadow_vld_q, shadow_vld_d;

  logic [PW-1:0]   prod_q [MUL_STAGES];
  logic            vld_q  [MUL_STAGES];
  logic            sgn_q  [MUL_STAGES];

  logic [PW-1:0]   a_x, b_x, prod;
  logic            issue;
  logic            ret_v, ret_s;
  logic [PW-1:0]   ret_p;
  logic [ACCW-1:0] addend, clamp, acc_next;
  logic [ACCW:0]   sum;
  logic            ovf;

  // Low 2W bits of the product of the extended operands are exact for both signednesses.
  always_comb begin
    issue = a_valid & b_valid;
    a_x   = signed_mode ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    b_x   = signed_mode ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod  = a_x * b_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
        vld_q[i]  <= 1'b0;
        sgn_q[i]  <= 1'b0;
      end
    end else begin
      prod_q[0] <= prod;
      vld_q[0]  <= issue;
      sgn_q[0]  <= signed_mode;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        sgn_q[i]  <= sgn_q[i-1];
      end
    end
  end

  always_comb begin
    ret_v  = vld_q[MUL_STAGES-1];
    ret_s  = sgn_q[MUL_STAGES-1];
    ret_p  = prod_q[MUL_STAGES-1];
    addend = '0;
    if (ret_v) begin
      addend = ACCW'(ret_p);
      if (ret_s) begin
        for (int unsigned i = PW; i < ACCW; i++) addend[i] = ret_p[PW-1];
      end
    end
    sum   = {1'b0, acc_q} + {1'b0, addend};
    ovf   = 1'b0;
    clamp = '1;
    if (SAT != 0 && ret_v) begin
      if (ret_s) begin
        ovf   = (acc_q[ACCW-1] == addend[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]);
        clamp = acc_q[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end else begin
        ovf   = sum[ACCW];
        clamp = '1;
      end
    end
    acc_next = ovf ? clamp : sum[ACCW-1:0];
  end

  // Commit takes priority over both clear and drain so a finishing block is never lost.
  always_comb begin
    acc_d        = acc_next;
    sat_d        = sat_q | ovf;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    if (acc_commit) begin
      shadow_d     = acc_next;
      shadow_vld_d = 1'b1;
      acc_d        = '0;
      sat_d        = 1'b0;
    end else begin
      if (drain_shift) begin
        shadow_d     = drain_in;
        shadow_vld_d = drain_in_valid;
      end
      if (acc_clear_block) begin
        acc_d = '0;
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      a_vld_q      <= 1'b0;
      b_vld_q      <= 1'b0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      a_vld_q      <= a_valid;
      b_vld_q      <= b_valid;
      if (a_valid) a_q <= a;
      if (b_valid) b_q <= b;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign a_valid_out     = a_vld_q;
  assign b_valid_out     = b_vld_q;
  assign drain_out       = shadow_q;
  assign drain_out_valid = shadow_vld_q;
  assign sat_flag        = sat_q;

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench: a downstream PE fed by an upstream PE over the drain chain,
// plus a 16-bit saturating PE.
module tb_pe_dbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic        sm = 1'b0;

  logic        av0 = 0, bv0 = 0, clr0 = 0, com0 = 0, sh0 = 0;
  logic [7:0]  ao0, bo0;
  logic        avo0, bvo0, dov0, sf0;
  logic [31:0] do0;

  logic        avu = 0, bvu = 0, comu = 0, shu = 0, divu = 0;
  logic [31:0] diu = '0;
  logic [7:0]  aou, bou;
  logic        avou, bvou, dovu, sfu;
  logic [31:0] dou;

  logic        avs = 0, bvs = 0, clrs = 0, coms = 0;
  logic [7:0]  aos, bos;
  logic        avos, bvos, dovs, sfs;
  logic [15:0] dos;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_dbuf u_pe (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_valid(av0), .b_valid(bv0),
    .signed_mode(sm), .a_out(ao0), .b_out(bo0), .a_valid_out(avo0), .b_valid_out(bvo0),
    .acc_clear_block(clr0), .acc_commit(com0), .drain_shift(sh0),
    .drain_in(dou), .drain_in_valid(dovu),
    .drain_out(do0), .drain_out_valid(dov0), .sat_flag(sf0)
  );

  pe_dbuf u_up (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_valid(avu), .b_valid(bvu),
    .signed_mode(sm), .a_out(aou), .b_out(bou), .a_valid_out(avou), .b_valid_out(bvou),
    .acc_clear_block(1'b0), .acc_commit(comu), .drain_shift(shu),
    .drain_in(diu), .drain_in_valid(divu),
    .drain_out(dou), .drain_out_valid(dovu), .sat_flag(sfu)
  );

  pe_dbuf #(.W(8), .ACCW(16), .MUL_STAGES(2), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .a_valid(avs), .b_valid(bvs),
    .signed_mode(sm), .a_out(aos), .b_out(bos), .a_valid_out(avos), .b_valid_out(bvos),
    .acc_clear_block(clrs), .acc_commit(coms), .drain_shift(1'b0),
    .drain_in(16'h0000), .drain_in_valid(1'b0),
    .drain_out(dos), .drain_out_valid(dovs), .sat_flag(sfs)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_drain_out", do0, 0);
    check("rst_drain_valid", dov0, 0);
    check("rst_a_valid_out", avo0, 0);
    check("rst_sat_flag", sfs, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // operand forwarding
    a = 8'd5; b = 8'd9; av0 = 1;
    tick();
    check("fwd_a_out", ao0, 5);
    check("fwd_a_valid", avo0, 1);
    check("fwd_b_valid", bvo0, 0);
    check("fwd_b_hold", bo0, 0);
    av0 = 0; a = 8'd7;
    tick();
    check("fwd_a_hold", ao0, 5);
    check("fwd_a_valid_drop", avo0, 0);

    // unsigned dot product, commit two cycles after the last pair
    sm = 0; a = 8'd255; b = 8'd255; av0 = 1; bv0 = 1;
    repeat (4) tick();
    av0 = 0; bv0 = 0;
    tick();
    com0 = 1; tick(); com0 = 0;
    check("udot_value", do0, 260100);
    check("udot_valid", dov0, 1);
    check("udot_no_sat", sf0, 0);

    // signed dot product; signed_mode drops before the last product retires
    sm = 1; a = 8'h80; b = 8'h7F; av0 = 1; bv0 = 1;
    tick();
    a = 8'd3; b = 8'hFB;
    tick();
    av0 = 0; bv0 = 0; sm = 0;
    tick();
    com0 = 1; tick(); com0 = 0;
    check("sdot_value", do0, 32'hFFFFC071);

    // commit coincides with last retire of block N while block N+1 issues
    sm = 0; av0 = 1; bv0 = 1;
    a = 8'd2;  b = 8'd3;  tick();
    a = 8'd4;  b = 8'd5;  tick();
    a = 8'd10; b = 8'd10; tick();
    a = 8'd1;  b = 8'd7;  com0 = 1; tick();
    com0 = 0; av0 = 0; bv0 = 0;
    check("overlap_block_n", do0, 26);
    tick();
    com0 = 1; tick(); com0 = 0;
    check("overlap_block_n1", do0, 107);

    // clear discards only the product retiring that cycle
    av0 = 1; bv0 = 1;
    a = 8'd6; b = 8'd7; tick();
    a = 8'd2; b = 8'd2; tick();
    av0 = 0; bv0 = 0; clr0 = 1; tick();
    clr0 = 0; tick();
    com0 = 1; tick(); com0 = 0;
    check("clear_partial", do0, 4);

    // commit and clear together: commit wins, accumulator restarts at zero
    a = 8'd3; b = 8'd3; av0 = 1; bv0 = 1; tick();
    av0 = 0; bv0 = 0; tick();
    com0 = 1; clr0 = 1; tick();
    com0 = 0; clr0 = 0;
    check("commit_beats_clear", do0, 9);
    com0 = 1; tick(); com0 = 0;
    check("commit_after_clear", do0, 0);

    // drain chain
    a = 8'd5; b = 8'd5; avu = 1; bvu = 1; tick();
    avu = 0; bvu = 0; a = 8'd9; b = 8'd9; av0 = 1; bv0 = 1; tick();
    av0 = 0; bv0 = 0; comu = 1; tick();
    comu = 0; com0 = 1; sh0 = 1; tick();
    com0 = 0;
    check("chain_commit_wins", do0, 81);
    check("chain_up_value", dou, 25);
    check("chain_up_valid", dovu, 1);
    shu = 1; diu = 32'h0000ABCD; divu = 0; tick();
    check("chain_shift1_value", do0, 25);
    check("chain_shift1_valid", dov0, 1);
    check("chain_up_loaded", dou, 32'h0000ABCD);
    check("chain_up_valid_drop", dovu, 0);
    shu = 0; tick();
    sh0 = 0;
    check("chain_shift2_value", do0, 32'h0000ABCD);
    check("chain_shift2_valid", dov0, 0);

    // saturation, positive clamp
    sm = 1; a = 8'd127; b = 8'd127; avs = 1; bvs = 1;
    repeat (3) tick();
    avs = 0; bvs = 0;
    tick();
    check("sat_before_ovf", sfs, 0);
    tick();
    check("sat_flag_set", sfs, 1);
    coms = 1; tick(); coms = 0;
    check("sat_pos_clamp", dos, 16'h7FFF);
    check("sat_flag_commit_clr", sfs, 0);

    // saturation, negative clamp
    a = 8'h80; b = 8'h7F; avs = 1; bvs = 1;
    repeat (3) tick();
    avs = 0; bvs = 0;
    repeat (2) tick();
    check("sat_neg_flag", sfs, 1);
    coms = 1; tick(); coms = 0;
    check("sat_neg_clamp", dos, 16'h8000);

    // clear removes a sticky flag
    a = 8'd127; b = 8'd127; avs = 1; bvs = 1;
    repeat (3) tick();
    avs = 0; bvs = 0;
    repeat (2) tick();
    check("sat_flag_again", sfs, 1);
    clrs = 1; tick(); clrs = 0;
    check("sat_flag_cleared", sfs, 0);

    // reset with two products in flight
    sm = 0; a = 8'd4; b = 8'd4; av0 = 1; bv0 = 1;
    repeat (2) tick();
    av0 = 0; bv0 = 0;
    rst_n = 1'b0;
    #1;
    check("midrst_drain_out", do0, 0);
    check("midrst_drain_valid", dov0, 0);
    check("midrst_a_out", ao0, 0);
    check("midrst_a_valid_out", avo0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    com0 = 1; tick(); com0 = 0;
    check("midrst_no_retire", do0, 0);
    check("midrst_commit_valid", dov0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
